writeback_unit: RTL



---
 rtl/wb_pkg.sv | 9 +
 rtl/writeback_unit_pending_counter.sv | 29 ++
 rtl/writeback_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: write-back source selects and register-name constants shared by the WB stage
package wb_pkg;
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;
  localparam logic [1:0] SRC_ILL  = 2'b11;
  localparam logic [2:0] REG_ZERO = 3'd0;
  localparam logic [2:0] LINK_REG = 3'd7;
endpackage

// File: rtl/writeback_unit_pending_counter.sv
// pending_counter: saturating up/down count of unretired writes to one register
module pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);
  logic [CNT_W-1:0] count_q, count_d;
  logic full, empty;
  // next count: clear dominates, saturate at both ends and flag the overflow/underflow
  always_comb begin
    full    = &count_q;
    empty   = ~|count_q;
    count_d = clr ? '0 :
              (inc & ~dec & ~full)  ? count_q + CNT_W'(1) :
              (dec & ~inc & ~empty) ? count_q - CNT_W'(1) : count_q;
    err     = ~clr & ((inc & ~dec & full) | (dec & ~inc & empty));
  end
  // count register
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: WB pipeline register driving the register file plus pending-write scoreboard
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic                issue_wen,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [REG_AW-1:0]   rs_a,
  input  logic [REG_AW-1:0]   rs_b,
  input  logic                mem_valid,
  input  logic                mem_wen,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic [1:0]          mem_src,
  input  logic [DATA_W-1:0]   mem_alu,
  input  logic [DATA_W-1:0]   mem_load,
  input  logic [DATA_W-1:0]   mem_pc1,
  output logic [REG_AW-1:0]   RW,
  output logic [DATA_W-1:0]   BusW,
  output logic                enableWrite,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] pending,
  output logic                err
);
  logic wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, en_q, en_d, err_q, err_d, mem_wr, retire;
  logic [REG_AW-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] cnt_err;
  assign cnt[0]     = '0;
  assign cnt_err[0] = 1'b0;
  assign retire     = wb_valid_q & wb_wen_q;
  // register 0 never gets a counter; every other register tracks its own in-flight writes
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (flush),
      .inc  (issue_valid & issue_wen & (issue_rd == REG_AW'(g))),
      .dec  (retire & (rw_q == REG_AW'(g))),
      .count(cnt[g]),
      .err  (cnt_err[g])
    );
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    assign pending[g] = |cnt[g];
  end
  // next WB state: flush kills the write but leaves address/data alone; illegal source drops data and flags err
  always_comb begin
    mem_wr     = mem_valid & mem_wen;
    wb_valid_d = ~flush & mem_valid;
    wb_wen_d   = ~flush & mem_wen;
    rw_d       = flush ? rw_q : mem_rd;
    busw_d     = flush ? busw_q :
                 (mem_src == SRC_ALU)  ? mem_alu :
                 (mem_src == SRC_LOAD) ? mem_load :
                 (mem_src == SRC_LINK) ? mem_pc1 : '0;
    en_d       = ~flush & mem_wr & (mem_rd != REG_AW'(REG_ZERO)) & (mem_src != SRC_ILL);
    err_d      = err_q | (|cnt_err) | (~flush & mem_wr & (mem_src == SRC_ILL));
  end
  // WB pipeline register and sticky error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      rw_q       <= '0;
      busw_q     <= '0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      rw_q       <= rw_d;
      busw_q     <= busw_d;
      en_q       <= en_d;
      err_q      <= err_d;
    end
  // a source whose last pending write is on the bus now is readable through the register file bypass
  always_comb begin
    busy_a = (|cnt[rs_a]) & ~((cnt[rs_a] == CNT_W'(1)) & en_q & (rw_q == rs_a));
    busy_b = (|cnt[rs_b]) & ~((cnt[rs_b] == CNT_W'(1)) & en_q & (rw_q == rs_b));
  end
  assign RW          = rw_q;
  assign BusW        = busw_q;
  assign enableWrite = en_q;
  assign err         = err_q;
endmodule
